// File: rtl/toggle_meter_if.sv
`default_nettype none
// ============================================================================
// Module      : toggle_meter_if
// Description : Measurement/handshake bundle for toggle_meter. The slave
//               modport is the meter, the master modport is whoever drives
//               the measured wave and consumes the published results.
// Revision    : 1.0 - initial release
// ============================================================================
interface toggle_meter_if #(
  parameter int WIDTH = 8
);
  logic             enable;     // active-low: 0 = measure, 1 = halt
  logic             in;         // square wave, asynchronous to clk
  logic             ack;        // consumer accepts the published result
  logic [WIDTH-1:0] high_time;
  logic [WIDTH-1:0] low_time;
  logic             valid;
  logic             sat;
  logic             overrun;

  modport slave (
    input  enable, in, ack,
    output high_time, low_time, valid, sat, overrun
  );

  modport master (
    output enable, in, ack,
    input  high_time, low_time, valid, sat, overrun
  );
endinterface
`default_nettype wire

// File: rtl/toggle_meter.sv
`default_nettype none
// ============================================================================
// Module      : toggle_meter
// Description : Measures how many clk cycles a synchronized square wave
//               spends high and low, publishing each high/low pair through a
//               valid/ack handshake with saturation and overrun reporting.
// Revision    : 1.0 - initial release
// ============================================================================
module toggle_meter #(
  parameter int WIDTH = 8
) (
  input  logic          clk,
  input  logic          reset,     // asynchronous, active-low
  toggle_meter_if.slave bus
);

  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ZERO = '0;
  localparam logic [WIDTH-1:0] CNT_ONE  = {{(WIDTH-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    MEAS_HIGH = 2'd1,
    MEAS_LOW  = 2'd2
  } state_t;

  // Synchronizer chain plus the delayed copy used for edge detection
  logic sync1;
  logic sync2;
  logic sync3;

  logic rise;
  logic fall;

  state_t           state;
  logic [WIDTH-1:0] counter;
  logic [WIDTH-1:0] count_next;
  logic [WIDTH-1:0] shadow_high;
  logic             sat_high;

  logic [WIDTH-1:0] high_time_r;
  logic [WIDTH-1:0] low_time_r;
  logic             valid_r;
  logic             sat_r;
  logic             overrun_r;

  // Two-flop synchronizer and a third stage; all clear together on reset so
  // a stale 1 can never look like an edge after reset is released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      sync3 <= 1'b0;
    end else begin
      sync1 <= bus.in;
      sync2 <= sync1;
      sync3 <= sync2;
    end
  end

  // A wave transition reaches sync2 two edges later and is acted on at the
  // third edge, giving a three-cycle transition-to-edge latency.
  assign rise = sync2 & ~sync3;
  assign fall = ~sync2 & sync3;

  // The counter sticks at its maximum instead of wrapping.
  assign count_next = (counter == CNT_MAX) ? counter : counter + CNT_ONE;

  // Measurement state machine with registered result outputs and handshake
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      counter     <= CNT_ZERO;
      shadow_high <= CNT_ZERO;
      sat_high    <= 1'b0;
      high_time_r <= CNT_ZERO;
      low_time_r  <= CNT_ZERO;
      valid_r     <= 1'b0;
      sat_r       <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      // An accepted ack consumes the result; a publish later in this block
      // overrides valid when a new result lands in the same cycle.
      if (valid_r && bus.ack) begin
        valid_r   <= 1'b0;
        overrun_r <= 1'b0;
      end

      if (bus.enable) begin
        // Halt abandons any measurement in flight; published data is kept.
        state       <= IDLE;
        counter     <= CNT_ZERO;
        shadow_high <= CNT_ZERO;
        sat_high    <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            counter <= CNT_ZERO;
            if (rise) begin
              state   <= MEAS_HIGH;
              counter <= CNT_ONE;
            end
          end

          MEAS_HIGH: begin
            if (fall) begin
              shadow_high <= counter;
              sat_high    <= (counter == CNT_MAX);
              counter     <= CNT_ONE;
              state       <= MEAS_LOW;
            end else begin
              counter <= count_next;
            end
          end

          MEAS_LOW: begin
            if (rise) begin
              if (!valid_r || bus.ack) begin
                high_time_r <= shadow_high;
                low_time_r  <= counter;
                sat_r       <= sat_high | (counter == CNT_MAX);
                valid_r     <= 1'b1;
              end else begin
                // Previous result still unconsumed: drop this one.
                overrun_r <= 1'b1;
              end
              counter <= CNT_ONE;
              state   <= MEAS_HIGH;
            end else begin
              counter <= count_next;
            end
          end

          default: begin
            state   <= IDLE;
            counter <= CNT_ZERO;
          end
        endcase
      end
    end
  end

  assign bus.high_time = high_time_r;
  assign bus.low_time  = low_time_r;
  assign bus.valid     = valid_r;
  assign bus.sat       = sat_r;
  assign bus.overrun   = overrun_r;

endmodule
`default_nettype wire

// File: tb/tb_toggle_meter.sv
`default_nettype none
// ============================================================================
// Module      : tb_toggle_meter
// Description : Self-checking bench for toggle_meter: table of high/low
//               pairs checked through a result scoreboard, plus directed
//               sequences for overrun, same-cycle ack, halt and async reset.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_toggle_meter;

  logic clk = 1'b0;
  logic reset;

  toggle_meter_if #(.WIDTH(8)) bus ();

  toggle_meter #(.WIDTH(8)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    int h;
    int l;
    int exp_high;
    int exp_low;
    bit exp_sat;
  } vec_t;

  typedef struct {
    int hi;
    int lo;
    bit s;
  } res_t;

  res_t sb[$];
  vec_t vecs[8];
  int   n_cmp = 0;
  int   n_err = 0;
  bit   auto_ack = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Drive the wave at a level for n cycles; returns 1 time unit after a posedge.
  task automatic hold(input logic v, input int n);
    bus.in = v;
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic halt(input int n);
    bus.enable = 1'b1;
    repeat (n) @(posedge clk);
    #1 bus.enable = 1'b0;
  endtask

  task automatic ack_pulse();
    bus.ack = 1'b1;
    @(posedge clk);
    #1 bus.ack = 1'b0;
  endtask

  // Consumer: on each valid result compare against the scoreboard and ack it.
  initial begin
    res_t r;
    bus.ack = 1'b0;
    forever begin
      @(negedge clk);
      if (auto_ack && reset === 1'b1 && bus.valid === 1'b1 && bus.ack === 1'b0) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL sb_underflow: got unexpected result %0d/%0d required none",
                   bus.high_time, bus.low_time);
        end else begin
          r = sb.pop_front();
          check("tbl_high", bus.high_time, r.hi);
          check("tbl_low",  bus.low_time,  r.lo);
          check("tbl_sat",  bus.sat,       r.s);
        end
        bus.ack = 1'b1;
        @(posedge clk);
        #1 bus.ack = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    res_t r;
    vecs[0] = '{5,   5,   5,   5,   1'b0};
    vecs[1] = '{3,   7,   3,   7,   1'b0};
    vecs[2] = '{1,   4,   1,   4,   1'b0};
    vecs[3] = '{12,  4,   12,  4,   1'b0};
    vecs[4] = '{300, 10,  255, 10,  1'b1};
    vecs[5] = '{10,  300, 10,  255, 1'b1};
    vecs[6] = '{254, 256, 254, 255, 1'b1};
    vecs[7] = '{5,   5,   5,   5,   1'b0};

    reset      = 1'b0;
    bus.enable = 1'b0;
    bus.in     = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_valid",   bus.valid,     0);
    check("rst_high",    bus.high_time, 0);
    check("rst_low",     bus.low_time,  0);
    check("rst_sat",     bus.sat,       0);
    check("rst_overrun", bus.overrun,   0);
    @(posedge clk);
    #1 reset = 1'b1;
    hold(1'b0, 3);

    // Table of high/low pairs, results consumed by the scoreboard process
    auto_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      hold(1'b1, vecs[i].h);
      hold(1'b0, vecs[i].l);
      r.hi = vecs[i].exp_high;
      r.lo = vecs[i].exp_low;
      r.s  = vecs[i].exp_sat;
      sb.push_back(r);
    end
    hold(1'b1, 4);
    hold(1'b0, 2);
    for (int i = 0; i < 60 && sb.size() > 0; i++) @(posedge clk);
    #1;
    check("sb_drain", sb.size(), 0);
    hold(1'b0, 4);
    auto_ack = 1'b0;
    hold(1'b0, 2);
    check("tbl_overrun", bus.overrun, 0);

    // Two results with no ack: first kept, overrun raised
    halt(2);
    hold(1'b0, 3);
    hold(1'b1, 4);
    hold(1'b0, 6);
    hold(1'b1, 3);
    hold(1'b0, 5);
    hold(1'b1, 2);
    hold(1'b0, 5);
    @(negedge clk);
    check("ovr_valid",   bus.valid,     1);
    check("ovr_high",    bus.high_time, 4);
    check("ovr_low",     bus.low_time,  6);
    check("ovr_flag",    bus.overrun,   1);
    @(posedge clk);
    #1 ack_pulse();
    @(negedge clk);
    check("ovr_ack_valid",   bus.valid,     0);
    check("ovr_ack_overrun", bus.overrun,   0);
    check("ovr_hold_high",   bus.high_time, 4);
    check("ovr_hold_low",    bus.low_time,  6);

    // Ack in the same cycle a new result lands
    @(posedge clk);
    #1 halt(2);
    hold(1'b0, 3);
    hold(1'b1, 6);
    hold(1'b0, 3);
    hold(1'b1, 7);
    hold(1'b0, 8);
    check("same_first_high", bus.high_time, 6);
    check("same_first_low",  bus.low_time,  3);
    bus.in = 1'b1;
    repeat (2) @(posedge clk);
    #1 bus.ack = 1'b1;
    @(posedge clk);
    #1 bus.ack = 1'b0;
    @(negedge clk);
    check("same_valid",   bus.valid,     1);
    check("same_high",    bus.high_time, 7);
    check("same_low",     bus.low_time,  8);
    check("same_overrun", bus.overrun,   0);
    @(posedge clk);
    #1 ack_pulse();

    // Halt in the middle of the low phase
    halt(2);
    hold(1'b0, 3);
    hold(1'b1, 5);
    hold(1'b0, 5);
    halt(4);
    hold(1'b0, 3);
    hold(1'b1, 6);
    hold(1'b0, 4);
    check("halt_no_pub", bus.valid, 0);
    hold(1'b1, 5);
    check("halt_valid", bus.valid,     1);
    check("halt_high",  bus.high_time, 6);
    check("halt_low",   bus.low_time,  4);
    check("halt_sat",   bus.sat,       0);

    // Asynchronous reset between edges while a result is pending
    bus.in = 1'b0;
    @(negedge clk);
    #2 reset = 1'b0;
    #1;
    check("arst_valid",   bus.valid,     0);
    check("arst_high",    bus.high_time, 0);
    check("arst_low",     bus.low_time,  0);
    check("arst_sat",     bus.sat,       0);
    check("arst_overrun", bus.overrun,   0);
    @(posedge clk);
    #1 reset = 1'b1;
    hold(1'b0, 5);
    check("post_rst_valid", bus.valid, 0);

    // Normal operation after reset
    hold(1'b1, 5);
    hold(1'b0, 5);
    hold(1'b1, 5);
    check("post_rst_high", bus.high_time, 5);
    check("post_rst_low",  bus.low_time,  5);
    check("post_rst_sat",  bus.sat,       0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/toggle_meter.md
TOGGLE_METER -- requirements
Module: toggle_meter

Interface
REQ-001 Parameter WIDTH, default 8: width of the cycle counter and of both measurement outputs.
REQ-002 clk  input  1  the single clock; all state updates on its rising edge.
REQ-003 reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 enable  input  1  active-low measurement enable (0 = measure, 1 = halt).
REQ-005 in  input  1  square wave from the upstream toggle counter; asynchronous to clk.
REQ-006 high_time  output  WIDTH  cycles the synchronized input spent high in the last published measurement.
REQ-007 low_time  output  WIDTH  cycles the synchronized input spent low in the last published measurement.
REQ-008 valid  output  1  high_time/low_time hold an unconsumed result.
REQ-009 ack  input  1  consumer acknowledges the result; sampled only while valid=1.
REQ-010 sat  output  1  at least one field of the published result saturated.
REQ-011 overrun  output  1  sticky flag: a completed result was dropped because valid was still 1.

Function
REQ-012 in SHALL pass through a 2-flop synchronizer; edge detection SHALL compare the 2nd stage with a 3rd registered copy.
REQ-013 Latency from an input transition to its detected-edge pulse SHALL be 3 clk cycles.
REQ-014 State machine SHALL have states IDLE, MEAS_HIGH and MEAS_LOW, with IDLE as the reset state.
REQ-015 IDLE: a rising edge with enable=0 -> MEAS_HIGH, counter=1; all other events are ignored.
REQ-016 MEAS_HIGH: counter increments each cycle with no edge; a falling edge -> shadow_high=counter, sat_high=(counter saturated), counter=1, -> MEAS_LOW.
REQ-017 MEAS_LOW: counter increments each cycle with no edge; a rising edge -> result published per REQ-019, counter=1, -> MEAS_HIGH.
REQ-018 The counter SHALL saturate at 2^WIDTH-1 and never wrap; a saturated field reports 2^WIDTH-1.
REQ-019 Publish when valid=0, or when valid=1 and ack=1 in the same cycle: high_time=shadow_high, low_time=counter, sat=sat_high|low saturated, valid=1.
REQ-020 Publish when valid=1 and ack=0: the result is discarded, outputs and valid are unchanged, and overrun is set to 1.
REQ-021 ack=1 with valid=1 and no publish SHALL clear valid the next cycle; high_time, low_time and sat hold their values.
REQ-022 ack with valid=0 SHALL have no effect.
REQ-023 overrun SHALL clear only on reset or on an accepted ack.
REQ-024 enable=1 in any state: -> IDLE next cycle, counter=0, shadow cleared; valid, outputs and overrun hold; the handshake (ack) remains functional.
REQ-025 In IDLE the counter SHALL hold at 0.
REQ-026 A measurement spanning a halt SHALL NOT be published; after enable returns to 0, the next rising edge restarts measurement.
REQ-027 Measured values SHALL equal the exact cycle distance between detected edges; a 50% square wave of half-period N cycles yields high_time=low_time=N.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, counter=0, shadow=0, synchronizer flops=0, high_time=0, low_time=0, valid=0, sat=0, overrun=0.
REQ-029 Reset deassertion SHALL be followed by IDLE behaviour; a stale synchronizer 1 SHALL NOT produce a false edge, because all synchronizer stages reset to 0 together.
REQ-030 Reset asserted mid-measurement or with valid=1 SHALL discard all results with no residual flags.

Verification
REQ-031 in toggles every 5 cycles, enable=0, ack pulsed on each valid -> first valid shows high_time=5, low_time=5, sat=0.
REQ-032 WIDTH=8, in held high 300 cycles then low 10 cycles then high -> high_time=255, low_time=10, sat=1.
REQ-033 Two results complete with ack held 0 -> outputs keep the first result and overrun=1; ack=1 -> valid=0 and overrun=0 the next cycle.
REQ-034 ack=1 in the same cycle a new result completes -> valid stays 1, outputs take the new values, overrun stays 0.
REQ-035 enable=1 mid-MEAS_LOW for 4 cycles, then 0 -> no result published for the interrupted measurement; the next full high/low pair measures correctly.
REQ-036 reset=0 asynchronously between clk edges while valid=1 -> all outputs read 0 before the next clk edge.
